vga_framebuffer_scanout: RTL

- Display-side reader of the 32x30-cell video memory that the CPU fills with WVM writes.
- Generates 640x480@60 VGA timing from the system clock and issues framebuffer read addresses ahead of the beam.
- Pipelines timing signals so each fetched pixel lines up with its sync and blank state, then drives the VGA pins.
- Also gives the CPU a vertical-blank indication so framebuffer updates can be tear-free.

---
 rtl/vga_framebuffer_scanout.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_framebuffer_scanout.sv
// Purpose: scans the 32x30-cell video memory out as 640x480@60 VGA, fetching ahead of the beam.
// Latency: read address is combinational from the counters; sync and colour pins follow one pixel tick later.
// Backpressure: none; iEnable low freezes the scan, holds the syncs and blanks RGB.
module vga_framebuffer_scanout #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CLK_DIV      = 2,
    parameter int COLOR_W      = 3,
    parameter int ADDR_W       = 10,
    parameter int CELL_SHIFT_X = 5,
    parameter int CELL_SHIFT_Y = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic [COLOR_W-1:0] iPixel,
    output logic [ADDR_W-1:0]  oReadAddress,
    output logic               oReadEnable,
    output logic               oHorizontalSync,
    output logic               oVerticalSync,
    output logic               oRed,
    output logic               oGreen,
    output logic               oBlue,
    output logic [9:0]         oColumnCount,
    output logic [9:0]         oRowCount,
    output logic               oFrameStart,
    output logic               oVBlank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    // Everything that reaches the VGA connector, registered together so it can never skew.
    typedef struct packed {
        logic hsyncN;
        logic vsyncN;
        logic red;
        logic green;
        logic blue;
    } pinStage_t;

    localparam pinStage_t PINS_IDLE = '{hsyncN: 1'b1, vsyncN: 1'b1, red: 1'b0, green: 1'b0, blue: 1'b0};

    logic [DIV_W-1:0] divCount;
    logic             tick;
    logic [9:0]       colCount;
    logic [9:0]       rowCount;
    logic [9:0]       rowNext;
    logic             colWrap;
    logic             rowWrap;
    logic             active;
    logic [9:0]       cellAddr;
    pinStage_t        pins;
    logic             frameStart;
    logic             vBlank;

    assign tick    = iEnable && (divCount == DIV_LAST);
    assign colWrap = (colCount == H_LAST);
    assign rowWrap = (rowCount == V_LAST);

    // Pixel-clock divider; parks wherever it is while the scan is frozen.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            divCount <= '0;
        end else if (iEnable) begin
            divCount <= (divCount == DIV_LAST) ? '0 : divCount + 1'b1;
        end
    end

    // Row value the counters will hold after the current tick.
    always_comb begin
        rowNext = rowCount;
        if (colWrap) begin
            rowNext = rowWrap ? 10'd0 : rowCount + 10'd1;
        end
    end

    // Beam position counters, one step per pixel tick.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            colCount <= '0;
            rowCount <= '0;
        end else if (tick) begin
            colCount <= colWrap ? 10'd0 : colCount + 10'd1;
            rowCount <= rowNext;
        end
    end

    // Stage 0: fetch address for the pixel under the counters; one memory word per 32x16 cell.
    assign active       = (colCount < H_ACT) && (rowCount < V_ACT);
    assign cellAddr     = {rowCount[CELL_SHIFT_Y+4:CELL_SHIFT_Y], colCount[CELL_SHIFT_X+4:CELL_SHIFT_X]};
    assign oReadAddress = ADDR_W'(cellAddr);
    assign oReadEnable  = active && !Reset;
    assign oColumnCount = colCount;
    assign oRowCount    = rowCount;

    // Stage 1: syncs and fetched colour for the same pixel land on the pins together.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pins <= PINS_IDLE;
        end else if (tick) begin
            pins.hsyncN <= !((colCount >= H_SYNC_START) && (colCount < H_SYNC_END));
            pins.vsyncN <= !((rowCount >= V_SYNC_START) && (rowCount < V_SYNC_END));
            pins.red    <= active && iPixel[2];
            pins.green  <= active && iPixel[1];
            pins.blue   <= active && iPixel[0];
        end else if (!iEnable) begin
            pins.red    <= 1'b0;
            pins.green  <= 1'b0;
            pins.blue   <= 1'b0;
        end
    end

    // Frame-start pulse and vertical-blank flag, aligned with the counter values they describe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            frameStart <= 1'b0;
            vBlank     <= 1'b0;
        end else begin
            frameStart <= tick && colWrap && rowWrap;
            if (tick) begin
                vBlank <= (rowNext >= V_ACT);
            end
        end
    end

    assign oHorizontalSync = pins.hsyncN;
    assign oVerticalSync   = pins.vsyncN;
    assign oRed            = pins.red;
    assign oGreen          = pins.green;
    assign oBlue           = pins.blue;
    assign oFrameStart     = frameStart;
    assign oVBlank         = vBlank;

endmodule
